// File: rtl/wm_control_panel.sv
`default_nettype none
// ============================================================================
// Module      : wm_control_panel
// Description : Washing-machine front panel: debounces start/pause buttons,
//               latches the program selection and sequences the run handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module wm_control_panel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACK_TIMEOUT     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_start,
    input  logic btn_pause,
    input  logic sel_double,
    input  logic sel_steam,
    input  logic done,
    output logic start,
    output logic double_wash,
    output logic dry_wash,
    output logic time_pause,
    output logic busy,
    output logic cycle_complete,
    output logic start_error
);

    localparam int c_db_w  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_ack_w = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_db_w-1:0]  c_db_max  = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_ack_w-1:0] c_ack_max = c_ack_w'(ACK_TIMEOUT - 1);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_start_req = 3'd1;
    localparam logic [2:0] c_st_run       = 3'd2;
    localparam logic [2:0] c_st_complete  = 3'd3;
    localparam logic [2:0] c_st_fault     = 3'd4;

    // bit 0: start button, bit 1: pause button
    logic [1:0] w_raw;
    logic [1:0] w_press;

    assign w_raw = {btn_pause, btn_start};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic              r_s1;
            logic              r_s2;
            logic              r_db;
            logic              r_db_d;
            logic [c_db_w-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s1   <= 1'b0;
                    r_s2   <= 1'b0;
                    r_db   <= 1'b0;
                    r_db_d <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_s1   <= w_raw[gi];
                    r_s2   <= r_s1;
                    r_db_d <= r_db;
                    if (r_s2 == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_db_max) begin
                        r_db  <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_db_w'(1);
                    end
                end
            end

            assign w_press[gi] = r_db & ~r_db_d;
        end
    endgenerate

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               r_dbl;
    logic               w_dbl_nxt;
    logic               r_stm;
    logic               w_stm_nxt;
    logic               r_pause;
    logic               w_pause_nxt;
    logic [c_ack_w-1:0] r_ack_cnt;
    logic [c_ack_w-1:0] w_ack_nxt;
    logic               r_start_error;
    logic               w_err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_dbl         <= 1'b0;
            r_stm         <= 1'b0;
            r_pause       <= 1'b0;
            r_ack_cnt     <= '0;
            r_start_error <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_dbl         <= w_dbl_nxt;
            r_stm         <= w_stm_nxt;
            r_pause       <= w_pause_nxt;
            r_ack_cnt     <= w_ack_nxt;
            r_start_error <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dbl_nxt   = r_dbl;
        w_stm_nxt   = r_stm;
        w_pause_nxt = r_pause;
        w_ack_nxt   = r_ack_cnt;
        w_err_nxt   = r_start_error;
        case (r_state)
            c_st_idle: begin
                if (w_press[0] && done) begin
                    // steam overrides double wash when both switches are on
                    w_dbl_nxt   = sel_double & ~sel_steam;
                    w_stm_nxt   = sel_steam;
                    w_err_nxt   = 1'b0;
                    w_ack_nxt   = '0;
                    w_pause_nxt = 1'b0;
                    w_state_nxt = c_st_start_req;
                end
            end
            c_st_start_req: begin
                if (!done) begin
                    w_state_nxt = c_st_run;
                end else if (r_ack_cnt == c_ack_max) begin
                    w_state_nxt = c_st_fault;
                end else begin
                    w_ack_nxt = r_ack_cnt + c_ack_w'(1);
                end
            end
            c_st_run: begin
                if (done) begin
                    w_pause_nxt = 1'b0;
                    w_state_nxt = c_st_complete;
                end else if (w_press[1]) begin
                    w_pause_nxt = ~r_pause;
                end
            end
            c_st_complete: begin
                w_state_nxt = c_st_idle;
            end
            c_st_fault: begin
                w_err_nxt   = 1'b1;
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    logic w_prog_active;

    assign w_prog_active  = (r_state == c_st_start_req) || (r_state == c_st_run);
    assign start          = (r_state == c_st_start_req);
    assign double_wash    = w_prog_active & r_dbl;
    assign dry_wash       = w_prog_active & r_stm;
    assign time_pause     = (r_state == c_st_run) & r_pause;
    assign busy           = (r_state != c_st_idle);
    assign cycle_complete = (r_state == c_st_complete);
    assign start_error    = r_start_error;

endmodule
`default_nettype wire

// File: tb/tb_wm_control_panel.sv
`default_nettype none
// ============================================================================
// Module      : tb_wm_control_panel
// Description : Directed scoreboard bench for the washing-machine front panel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wm_control_panel;

    logic clk = 1'b0;
    logic rst;
    logic btn_start;
    logic btn_pause;
    logic sel_double;
    logic sel_steam;
    logic done;
    logic start;
    logic double_wash;
    logic dry_wash;
    logic time_pause;
    logic busy;
    logic cycle_complete;
    logic start_error;

    wm_control_panel #(
        .DEBOUNCE_CYCLES (4),
        .ACK_TIMEOUT     (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_start      (btn_start),
        .btn_pause      (btn_pause),
        .sel_double     (sel_double),
        .sel_steam      (sel_steam),
        .done           (done),
        .start          (start),
        .double_wash    (double_wash),
        .dry_wash       (dry_wash),
        .time_pause     (time_pause),
        .busy           (busy),
        .cycle_complete (cycle_complete),
        .start_error    (start_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [6:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Output vector order: start, double_wash, dry_wash, time_pause, busy, cycle_complete, start_error
    function automatic logic [6:0] outs();
        return {start, double_wash, dry_wash, time_pause, busy, cycle_complete, start_error};
    endfunction

    function automatic logic [6:0] vec(input logic st, input logic dw, input logic dr,
                                       input logic tp, input logic bz, input logic cc,
                                       input logic se);
        return {st, dw, dr, tp, bz, cc, se};
    endfunction

    task automatic expect_out(input string tag, input logic [6:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t       x;
        logic [6:0] o;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty observed=%b expected=<entry>", outs());
        end else begin
            x = sb.pop_front();
            o = outs();
            assert (o === x.exp) else begin
                n_err++;
                $error("FAIL %s observed=%b expected=%b", x.tag, o, x.exp);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // From IDLE with done=1: press start, machine drops done one cycle after start; ends in RUN.
    task automatic start_run(input logic dbl, input logic stm, input logic se_pre);
        btn_start = 1'b1;
        expect_out("pre_debounce", vec(0, 0, 0, 0, 0, 0, se_pre));
        expect_out("start_rise",   vec(1, dbl, stm, 0, 1, 0, 0));
        expect_out("start_hold",   vec(1, dbl, stm, 0, 1, 0, 0));
        expect_out("run_entry",    vec(0, dbl, stm, 0, 1, 0, 0));
        tick(6);
        check_out();
        tick(1);
        check_out();
        tick(1);
        check_out();
        done = 1'b0;
        tick(1);
        check_out();
        tick(1);
        btn_start = 1'b0;
    endtask

    task automatic finish_run();
        done = 1'b1;
        expect_out("complete_pulse", vec(0, 0, 0, 0, 1, 1, 0));
        expect_out("idle_after",     vec(0, 0, 0, 0, 0, 0, 0));
        tick(1);
        check_out();
        tick(1);
        check_out();
    endtask

    task automatic pause_press(input logic tp_before);
        btn_pause = 1'b1;
        expect_out("pause_pre",    vec(0, 0, 0, tp_before, 1, 0, 0));
        expect_out("pause_toggle", vec(0, 0, 0, ~tp_before, 1, 0, 0));
        tick(6);
        check_out();
        tick(1);
        check_out();
        btn_pause = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        btn_start  = 1'b0;
        btn_pause  = 1'b0;
        sel_double = 1'b0;
        sel_steam  = 1'b0;
        done       = 1'b1;

        // reset state
        expect_out("reset_state", vec(0, 0, 0, 0, 0, 0, 0));
        tick(2);
        check_out();
        rst = 1'b0;
        tick(3);

        // normal run
        start_run(1'b0, 1'b0, 1'b0);
        expect_out("run_hold", vec(0, 0, 0, 0, 1, 0, 0));
        tick(2);
        check_out();
        finish_run();
        tick(10);

        // bouncing start button never accepted
        for (int i = 0; i < 20; i++) expect_out("bounce_quiet", vec(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 12; i++) begin
            btn_start = ((i % 4) < 2);
            tick(1);
            check_out();
        end
        btn_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check_out();
        end

        // steam wins over double; switches changed mid-run are ignored
        sel_double = 1'b1;
        sel_steam  = 1'b1;
        start_run(1'b0, 1'b1, 1'b0);
        sel_double = 1'b0;
        sel_steam  = 1'b0;
        for (int i = 0; i < 3; i++) expect_out("prog_latched", vec(0, 0, 1, 0, 1, 0, 0));
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_out();
        end
        finish_run();
        tick(10);

        // pause toggling, then a pause press colliding with done
        start_run(1'b0, 1'b0, 1'b0);
        pause_press(1'b0);
        expect_out("pause_held", vec(0, 0, 0, 1, 1, 0, 0));
        tick(10);
        check_out();
        pause_press(1'b1);
        tick(10);
        btn_pause = 1'b1;
        expect_out("pause3_pre", vec(0, 0, 0, 0, 1, 0, 0));
        expect_out("done_wins",  vec(0, 0, 0, 0, 1, 1, 0));
        expect_out("idle_after", vec(0, 0, 0, 0, 0, 0, 0));
        tick(6);
        check_out();
        done = 1'b1;
        tick(1);
        check_out();
        tick(1);
        check_out();
        btn_pause = 1'b0;
        tick(10);

        // start never acknowledged -> fault after 8 cycles of start
        btn_start = 1'b1;
        expect_out("fault_pre", vec(0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) expect_out("ack_wait", vec(1, 0, 0, 0, 1, 0, 0));
        expect_out("fault_state", vec(0, 0, 0, 0, 1, 0, 0));
        expect_out("fault_idle",  vec(0, 0, 0, 0, 0, 0, 1));
        tick(6);
        check_out();
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check_out();
            if (i == 3) btn_start = 1'b0;
        end
        tick(1);
        check_out();
        tick(1);
        check_out();
        expect_out("error_sticky", vec(0, 0, 0, 0, 0, 0, 1));
        tick(10);
        check_out();
        start_run(1'b0, 1'b0, 1'b1);
        finish_run();
        tick(10);

        // asynchronous reset mid-run while paused
        start_run(1'b0, 1'b0, 1'b0);
        pause_press(1'b0);
        tick(2);
        #2;
        rst = 1'b1;
        expect_out("async_reset", vec(0, 0, 0, 0, 0, 0, 0));
        #1;
        check_out();
        tick(2);
        done = 1'b1;
        rst  = 1'b0;
        tick(3);
        sel_double = 1'b1;
        start_run(1'b1, 1'b0, 1'b0);
        finish_run();

        if (sb.size() != 0) begin
            n_err++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
